// File: rtl/vga_pkg.sv
// Shared VGA field widths and the screen-mux state type.
package vga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int RGB_W    = 12;

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    ARMED = 2'd1,
    GAP   = 2'd2
  } mux_state_t;

endpackage

// File: rtl/vga_if.sv
// One VGA stream: counters, sync/blank flags and pixel colour.
// The "out" side drives the stream, the "in" side consumes it.
interface vga_if;
  import vga_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [HCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                hblnk;
  logic                vblnk;
  logic [RGB_W-1:0]    rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/frame_edge_det.sv
// Flags the first pixel of a frame (hcount == 0 and vcount == 0) on the
// currently selected source's counters.
module frame_edge_det
  import vga_pkg::*;
(
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [HCOUNT_W-1:0] vcount,
  output logic                frame_start
);

  // Frame start is the single cycle at the origin of the raster.
  assign frame_start = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/screen_mux_sync.sv
// Frame-synchronous VGA source multiplexer. A select request is armed and
// takes effect only at a frame start of the shown source, optionally after
// GAP_FRAMES black frames, so the picture never tears mid-frame.
//
// Request handshake: sel_valid is a one-cycle strobe that samples sel_req;
// there is no ready. Out-of-range requests, and requests equal to the
// shown source (except a cancel while ARMED), are dropped silently.
module screen_mux_sync
  import vga_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int GAP_FRAMES = 1,
  parameter int SEL_W      = $clog2(NUM_SRC)
)
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SEL_W-1:0]                 sel_req,
  input  logic                             sel_valid,
  input  logic [NUM_SRC-1:0][HCOUNT_W-1:0] src_hcount,
  input  logic [NUM_SRC-1:0][HCOUNT_W-1:0] src_vcount,
  input  logic [NUM_SRC-1:0]               src_hsync,
  input  logic [NUM_SRC-1:0]               src_vsync,
  input  logic [NUM_SRC-1:0]               src_hblnk,
  input  logic [NUM_SRC-1:0]               src_vblnk,
  input  logic [NUM_SRC-1:0][RGB_W-1:0]    src_rgb,
  vga_if.out                               bg_out,
  output logic [SEL_W-1:0]                 active_sel,
  output logic                             busy,
  output logic                             switch_done,
  output mux_state_t                       dbg_state
);

  localparam logic [SEL_W:0] SRC_LIMIT = (SEL_W+1)'(NUM_SRC);
  localparam logic [3:0]     GAP_INIT  = 4'(GAP_FRAMES);

  mux_state_t       state;
  logic [SEL_W-1:0] pending_sel;
  logic [3:0]       gap_cnt;

  logic             frame_start;
  logic             req_new;
  logic             cancel;
  logic             switch_now;
  logic             gap_enter;
  logic             blank_next;
  logic [SEL_W-1:0] pend_eff;
  logic [SEL_W-1:0] sel_mux;

  frame_edge_det u_edge (
    .hcount      (src_hcount[active_sel]),
    .vcount      (src_vcount[active_sel]),
    .frame_start (frame_start)
  );

  // Decode this cycle's request and decide whether the frame start switches,
  // enters the gap, or neither; a request in the same cycle already counts.
  always_comb begin
    req_new    = sel_valid && ({1'b0, sel_req} < SRC_LIMIT) && (sel_req != active_sel);
    cancel     = (state == ARMED) && sel_valid && (sel_req == active_sel);
    pend_eff   = req_new ? sel_req : pending_sel;
    switch_now = 1'b0;
    gap_enter  = 1'b0;
    if (frame_start && !cancel) begin
      if (state == ARMED) begin
        if (GAP_FRAMES == 0) switch_now = 1'b1;
        else                 gap_enter  = 1'b1;
      end else if ((state == GAP) && (gap_cnt == 4'd1)) begin
        switch_now = 1'b1;
      end
    end
    // The output register follows the source that will be active after this
    // edge, so the new source's first pixel lands on bg_out (0,0).
    sel_mux    = switch_now ? pend_eff : active_sel;
    blank_next = gap_enter || ((state == GAP) && !switch_now);
  end

  // Switch control FSM: arm on request, count gap frames, swap at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHOW;
      active_sel  <= '0;
      pending_sel <= '0;
      gap_cnt     <= '0;
      busy        <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      switch_done <= switch_now;
      case (state)
        SHOW: begin
          if (req_new) begin
            pending_sel <= sel_req;
            state       <= ARMED;
            busy        <= 1'b1;
          end
        end
        ARMED: begin
          if (cancel) begin
            state <= SHOW;
            busy  <= 1'b0;
          end else begin
            pending_sel <= pend_eff;
            if (switch_now) begin
              active_sel <= pend_eff;
              state      <= SHOW;
              busy       <= 1'b0;
            end else if (gap_enter) begin
              gap_cnt <= GAP_INIT;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          pending_sel <= pend_eff;
          if (switch_now) begin
            active_sel <= pend_eff;
            gap_cnt    <= '0;
            state      <= SHOW;
            busy       <= 1'b0;
          end else if (frame_start) begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= SHOW;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered output stream: timing always copied, colour blanked in gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_out.hcount <= '0;
      bg_out.vcount <= '0;
      bg_out.hsync  <= 1'b0;
      bg_out.vsync  <= 1'b0;
      bg_out.hblnk  <= 1'b0;
      bg_out.vblnk  <= 1'b0;
      bg_out.rgb    <= '0;
    end else begin
      bg_out.hcount <= src_hcount[sel_mux];
      bg_out.vcount <= src_vcount[sel_mux];
      bg_out.hsync  <= src_hsync[sel_mux];
      bg_out.vsync  <= src_vsync[sel_mux];
      bg_out.hblnk  <= src_hblnk[sel_mux];
      bg_out.vblnk  <= src_vblnk[sel_mux];
      bg_out.rgb    <= blank_next ? '0 : src_rgb[sel_mux];
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_screen_mux_sync.sv
// Bench for screen_mux_sync: two instances (GAP_FRAMES=2 and GAP_FRAMES=0)
// share genlocked sources with random sync/colour, checked every cycle
// against a frame-level reference model plus directed scenario checks.
module tb_screen_mux_sync;
  import vga_pkg::*;

  localparam int NUM   = 4;
  localparam int SW    = 3;
  localparam int H_TOT = 16;
  localparam int V_TOT = 8;
  localparam int BOUND = 4 * H_TOT * V_TOT;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0]                 sel_req;
  logic                          sel_valid;
  logic [NUM-1:0][HCOUNT_W-1:0]  src_hcount;
  logic [NUM-1:0][HCOUNT_W-1:0]  src_vcount;
  logic [NUM-1:0]                src_hsync;
  logic [NUM-1:0]                src_vsync;
  logic [NUM-1:0]                src_hblnk;
  logic [NUM-1:0]                src_vblnk;
  logic [NUM-1:0][RGB_W-1:0]     src_rgb;

  vga_if bg_a ();
  vga_if bg_b ();
  logic [SW-1:0] act_a, act_b;
  logic          busy_a, busy_b, done_a, done_b;
  mux_state_t    st_a, st_b;

  screen_mux_sync #(.NUM_SRC(NUM), .GAP_FRAMES(2), .SEL_W(SW)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_valid(sel_valid),
    .src_hcount(src_hcount), .src_vcount(src_vcount),
    .src_hsync(src_hsync), .src_vsync(src_vsync),
    .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_rgb(src_rgb),
    .bg_out(bg_a), .active_sel(act_a), .busy(busy_a),
    .switch_done(done_a), .dbg_state(st_a)
  );

  screen_mux_sync #(.NUM_SRC(NUM), .GAP_FRAMES(0), .SEL_W(SW)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_valid(sel_valid),
    .src_hcount(src_hcount), .src_vcount(src_vcount),
    .src_hsync(src_hsync), .src_vsync(src_vsync),
    .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_rgb(src_rgb),
    .bg_out(bg_b), .active_sel(act_b), .busy(busy_b),
    .switch_done(done_b), .dbg_state(st_b)
  );

  // ---------------- checking ----------------
  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: mode 0=showing, 1=armed, 2=black gap.
  int   m_gap   [2];
  int   m_mode  [2];
  int   m_shown [2];
  int   m_pend  [2];
  int   m_left  [2];
  logic m_busy  [2];
  logic m_done  [2];
  logic [HCOUNT_W-1:0] e_h [2];
  logic [HCOUNT_W-1:0] e_v [2];
  logic [3:0]          e_syn [2];
  logic [RGB_W-1:0]    e_rgb [2];
  logic [SW-1:0]       exp_q [$];

  int h_app;
  int v_app;

  task automatic model_step();
    int  sr;
    bit  fs, okreq, sw;
    sr = int'(sel_req);
    fs = (h_app == 0) && (v_app == 0);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = 0; m_shown[k] = 0; m_pend[k] = 0; m_left[k] = 0;
        m_busy[k] = 1'b0; m_done[k] = 1'b0;
        e_h[k] = '0; e_v[k] = '0; e_syn[k] = '0; e_rgb[k] = '0;
      end else begin
        sw = 1'b0;
        m_done[k] = 1'b0;
        okreq = sel_valid && (sr < NUM) && (sr != m_shown[k]);
        case (m_mode[k])
          0: if (okreq) begin m_pend[k] = sr; m_mode[k] = 1; m_busy[k] = 1'b1; end
          1: begin
            if (sel_valid && sr == m_shown[k]) begin
              m_mode[k] = 0; m_busy[k] = 1'b0;
            end else begin
              if (okreq) m_pend[k] = sr;
              if (fs) begin
                if (m_gap[k] == 0) sw = 1'b1;
                else begin m_left[k] = m_gap[k]; m_mode[k] = 2; end
              end
            end
          end
          default: begin
            if (okreq) m_pend[k] = sr;
            if (fs) begin
              if (m_left[k] == 1) sw = 1'b1;
              else m_left[k] = m_left[k] - 1;
            end
          end
        endcase
        if (sw) begin
          m_shown[k] = m_pend[k]; m_mode[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b1;
          if (k == 0) exp_q.push_back(SW'(m_shown[0]));
        end
        e_h[k]   = src_hcount[m_shown[k]];
        e_v[k]   = src_vcount[m_shown[k]];
        e_syn[k] = {src_hsync[m_shown[k]], src_vsync[m_shown[k]],
                    src_hblnk[m_shown[k]], src_vblnk[m_shown[k]]};
        e_rgb[k] = (m_mode[k] == 2) ? '0 : src_rgb[m_shown[k]];
      end
    end
  endtask

  task automatic check_dut(input int k, input logic [HCOUNT_W-1:0] h, input logic [HCOUNT_W-1:0] v,
                           input logic [3:0] syn, input logic [RGB_W-1:0] rgb, input logic [SW-1:0] sel,
                           input logic bsy, input logic dn, input mux_state_t st);
    mux_state_t exp_st;
    exp_st = (m_mode[k] == 0) ? SHOW : (m_mode[k] == 1) ? ARMED : GAP;
    check_eq($sformatf("d%0d_hcount", k), h, e_h[k]);
    check_eq($sformatf("d%0d_vcount", k), v, e_v[k]);
    check_eq($sformatf("d%0d_sync", k), syn, e_syn[k]);
    check_eq($sformatf("d%0d_rgb", k), rgb, e_rgb[k]);
    check_eq($sformatf("d%0d_active_sel", k), sel, SW'(m_shown[k]));
    check_eq($sformatf("d%0d_busy", k), bsy, m_busy[k]);
    check_eq($sformatf("d%0d_switch_done", k), dn, m_done[k]);
    check_eq($sformatf("d%0d_state", k), st, exp_st);
  endtask

  task automatic check_all();
    check_dut(0, bg_a.hcount, bg_a.vcount, {bg_a.hsync, bg_a.vsync, bg_a.hblnk, bg_a.vblnk},
              bg_a.rgb, act_a, busy_a, done_a, st_a);
    check_dut(1, bg_b.hcount, bg_b.vcount, {bg_b.hsync, bg_b.vsync, bg_b.hblnk, bg_b.vblnk},
              bg_b.rgb, act_b, busy_b, done_b, st_b);
    if (done_a) begin
      check_eq("sb_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check_eq("sb_sel", act_a, exp_q.pop_front());
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_src();
    for (int i = 0; i < NUM; i++) begin
      src_hcount[i] = HCOUNT_W'(h_app);
      src_vcount[i] = HCOUNT_W'(v_app);
      src_hsync[i]  = 1'($urandom_range(0, 1));
      src_vsync[i]  = 1'($urandom_range(0, 1));
      src_hblnk[i]  = 1'($urandom_range(0, 1));
      src_vblnk[i]  = 1'($urandom_range(0, 1));
      src_rgb[i]    = RGB_W'($urandom);
    end
  endtask

  // One clock: check what the last edge produced, then apply next inputs.
  task automatic tick(input logic v_en, input logic [SW-1:0] req);
    @(posedge clk);
    #1;
    model_step();
    check_all();
    if (h_app == H_TOT - 1) begin
      h_app = 0;
      v_app = (v_app == V_TOT - 1) ? 0 : v_app + 1;
    end else begin
      h_app = h_app + 1;
    end
    drive_src();
    sel_valid = v_en;
    sel_req   = req;
  endtask

  task automatic run_frames(input int n);
    repeat (n * H_TOT * V_TOT) tick(1'b0, '0);
  endtask

  // Advance until the applied raster position is (v, h).
  task automatic run_until_pos(input int v, input int h);
    int cnt;
    cnt = 0;
    while (!(v_app == v && h_app == h) && cnt < BOUND) begin
      tick(1'b0, '0);
      cnt++;
    end
    check_eq("wait_pos_timeout", cnt < BOUND, 1'b1);
  endtask

  task automatic run_until_mode(input int k, input int mode);
    int cnt;
    cnt = 0;
    while (m_mode[k] != mode && cnt < BOUND) begin
      tick(1'b0, '0);
      cnt++;
    end
    check_eq("wait_mode_timeout", cnt < BOUND, 1'b1);
  endtask

  task automatic async_reset_check();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_a_hcount", bg_a.hcount, 0);
    check_eq("rst_a_vcount", bg_a.vcount, 0);
    check_eq("rst_a_sync", {bg_a.hsync, bg_a.vsync, bg_a.hblnk, bg_a.vblnk}, 0);
    check_eq("rst_a_rgb", bg_a.rgb, 0);
    check_eq("rst_a_sel", act_a, 0);
    check_eq("rst_a_busy", busy_a, 0);
    check_eq("rst_a_done", done_a, 0);
    check_eq("rst_a_state", st_a, SHOW);
    check_eq("rst_b_rgb", bg_b.rgb, 0);
    check_eq("rst_b_busy", busy_b, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    m_gap[0] = 2;
    m_gap[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_shown[k] = 0; m_pend[k] = 0; m_left[k] = 0;
      m_busy[k] = 1'b0; m_done[k] = 1'b0;
    end
    rst_n = 1'b0; sel_valid = 1'b0; sel_req = '0;
    h_app = 0; v_app = 0;
    drive_src();
    repeat (3) tick(1'b0, '0);
    rst_n = 1'b1;

    // Reset release: source 0 mirrored.
    run_frames(2);
    check_eq("post_reset_sel", act_a, 0);
    check_eq("post_reset_busy", busy_a, 0);

    // Mid-frame request for source 2.
    run_until_pos(3, 5);
    tick(1'b1, 3'd2);
    tick(1'b0, '0);
    check_eq("req2_busy_now", busy_a, 1);
    check_eq("req2_sel_held", act_a, 0);
    run_frames(4);
    check_eq("req2_switched_a", act_a, 2);
    check_eq("req2_switched_b", act_b, 2);

    // Switch to source 1 through two black frames.
    run_until_pos(4, 2);
    tick(1'b1, 3'd1);
    run_frames(4);
    check_eq("req1_switched_a", act_a, 1);

    // In gap: overwrite pending with 3, then a request equal to active is dropped.
    run_until_pos(2, 3);
    tick(1'b1, 3'd2);
    run_until_mode(0, 2);
    tick(1'b1, 3'd3);
    tick(1'b1, 3'd1);
    run_frames(4);
    check_eq("gap_overwrite_a", act_a, 3);

    // Armed cancel: request 0 then request the active source in the same frame.
    run_until_pos(2, 0);
    tick(1'b1, 3'd0);
    tick(1'b0, '0);
    tick(1'b1, 3'd3);
    tick(1'b0, '0);
    check_eq("cancel_busy_a", busy_a, 0);
    run_frames(2);
    check_eq("cancel_sel_a", act_a, 3);

    // Ignored requests: out of range and equal to active.
    tick(1'b1, 3'd5);
    tick(1'b0, '0);
    check_eq("ignore_oor_busy", busy_a, 0);
    tick(1'b1, 3'd3);
    tick(1'b0, '0);
    check_eq("ignore_same_busy", busy_a, 0);

    // Request coincident with frame start is deferred one frame.
    run_until_pos(V_TOT - 1, H_TOT - 1);
    tick(1'b1, 3'd1);
    tick(1'b0, '0);
    check_eq("fs_req_busy_b", busy_b, 1);
    check_eq("fs_req_held_b", act_b, 3);
    run_frames(4);
    check_eq("fs_req_done_b", act_b, 1);

    // Reset pulsed mid-gap.
    run_until_pos(3, 3);
    tick(1'b1, 3'd2);
    run_until_mode(0, 2);
    run_until_pos(2, 4);
    async_reset_check();
    repeat (3) tick(1'b0, '0);
    rst_n = 1'b1;
    run_frames(3);
    check_eq("rst_gap_sel_a", act_a, 0);
    check_eq("rst_gap_state_a", st_a, SHOW);

    // Randomized requests.
    repeat (20 * H_TOT * V_TOT)
      tick(($urandom_range(0, 63) == 0), SW'($urandom_range(0, 7)));
    run_frames(4);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
